// File: rtl/k_means_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : k_means_iter_ctrl
//  Description : Iteration sequencer for the k-means operator. Each iteration
//                loads the centroids, streams the data set and waits for the
//                centroid update. Host reads are chunked into descriptors that
//                never cross a MAX_XFER_BYTES boundary. The controller reports
//                done, convergence and the iteration count.
//                Optional macro KMEANS_ITER_CTRL_PERF_EN adds the busy-cycle
//                and read-stall performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module k_means_iter_ctrl #(
    parameter int BEAT_BYTES       = 64,
    parameter int MAX_XFER_BYTES   = 4096,
    parameter int NUM_CLUSTER_BITS = 3,
    parameter int MAX_DEPTH_BITS   = 9
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CLUSTER_BITS:0] num_clusters,
    input  logic [MAX_DEPTH_BITS:0]   data_dim,
    input  logic [63:0]               data_set_size,
    input  logic [15:0]               max_iter,
    input  logic [31:0]               conv_thresh,
    input  logic [63:0]               cent_base,
    input  logic [63:0]               data_base,
    output logic                      rd_req_valid,
    input  logic                      rd_req_ready,
    output logic [63:0]               rd_req_addr,
    output logic [31:0]               rd_req_len,
    output logic                      rd_req_cent,
    input  logic                      dp_cent_done,
    input  logic                      dp_pass_done,
    input  logic                      upd_done,
    input  logic [31:0]               upd_delta,
    output logic                      iter_start,
    output logic                      busy,
    output logic                      done,
    output logic                      converged,
    output logic                      err,
    output logic [15:0]               iter_count
`ifdef KMEANS_ITER_CTRL_PERF_EN
    ,
    output logic [63:0]               perf_cycles,
    output logic [63:0]               perf_stall
`endif
);

    localparam logic [31:0] c_xfer_bytes = 32'(MAX_XFER_BYTES);
    localparam logic [31:0] c_xfer_mask  = c_xfer_bytes - 32'd1;
    localparam logic [63:0] c_beat_bytes = 64'(BEAT_BYTES);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_ITER      = 4'd2,
        S_REQ_CENT  = 4'd3,
        S_WAIT_CENT = 4'd4,
        S_REQ_DATA  = 4'd5,
        S_WAIT_DATA = 4'd6,
        S_WAIT_UPD  = 4'd7,
        S_EVAL      = 4'd8,
        S_FIN       = 4'd9
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_CLUSTER_BITS:0] k_q, k_d;
    logic [MAX_DEPTH_BITS:0]   dim_q, dim_d;
    logic [63:0]               size_q, size_d;
    logic [15:0]               maxi_q, maxi_d;
    logic [31:0]               thresh_q, thresh_d;
    logic [63:0]               cbase_q, cbase_d;
    logic [63:0]               dbase_q, dbase_d;
    logic [63:0]               addr_q, addr_d;
    logic [63:0]               rem_q, rem_d;
    logic                      pend_q, pend_d;
    logic [31:0]               delta_q, delta_d;
    logic [15:0]               iter_q, iter_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      conv_q, conv_d;
    logic                      err_q, err_d;
`ifdef KMEANS_ITER_CTRL_PERF_EN
    logic [63:0]               perf_cycles_q, perf_cycles_d;
    logic [63:0]               perf_stall_q, perf_stall_d;
`endif

    logic [31:0] w_chunk;
    logic [31:0] w_len;
    logic [31:0] w_cent_bytes;
    logic [63:0] w_data_bytes;
    logic        w_in_req;
    logic        w_hs;
    logic        w_last;

    // Room left before the next transfer boundary bounds each descriptor
    assign w_chunk      = c_xfer_bytes - (addr_q[31:0] & c_xfer_mask);
    assign w_len        = (rem_q < {32'd0, w_chunk}) ? rem_q[31:0] : w_chunk;
    assign w_cent_bytes = 32'(k_q) * 32'(dim_q) * 32'd4;
    assign w_data_bytes = size_q * c_beat_bytes;
    assign w_in_req     = (state_q == S_REQ_CENT) || (state_q == S_REQ_DATA);
    assign w_hs         = rd_req_valid && rd_req_ready;
    assign w_last       = w_hs && (rem_q == {32'd0, w_len});

    assign rd_req_valid = w_in_req && (rem_q != 64'd0);
    assign rd_req_addr  = addr_q;
    assign rd_req_len   = w_len;
    assign rd_req_cent  = (state_q == S_REQ_CENT);
    assign iter_start   = (state_q == S_ITER);
    assign busy         = busy_q;
    assign done         = done_q;
    assign converged    = conv_q;
    assign err          = err_q;
    assign iter_count   = iter_q;
`ifdef KMEANS_ITER_CTRL_PERF_EN
    assign perf_cycles  = perf_cycles_q;
    assign perf_stall   = perf_stall_q;
`endif

    // Next-state, descriptor walk and status bookkeeping
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        dim_d    = dim_q;
        size_d   = size_q;
        maxi_d   = maxi_q;
        thresh_d = thresh_q;
        cbase_d  = cbase_q;
        dbase_d  = dbase_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        pend_d   = pend_q;
        delta_d  = delta_q;
        iter_d   = iter_q;
        busy_d   = busy_q;
        done_d   = done_q;
        conv_d   = conv_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d      = num_clusters;
                    dim_d    = data_dim;
                    size_d   = data_set_size;
                    maxi_d   = (max_iter == 16'd0) ? 16'd1 : max_iter;
                    thresh_d = conv_thresh;
                    cbase_d  = cent_base;
                    dbase_d  = data_base;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    conv_d   = 1'b0;
                    iter_d   = 16'd0;
                    busy_d   = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((k_q == '0) || (dim_q == '0) || (size_q == 64'd0)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d   = {32'd0, w_cent_bytes};
                addr_d  = cbase_q;
                pend_d  = 1'b0;
                state_d = S_REQ_CENT;
            end
            S_REQ_CENT, S_REQ_DATA: begin
                if (rem_q == 64'd0) begin
                    state_d = (state_q == S_REQ_CENT) ? S_WAIT_CENT : S_WAIT_DATA;
                end else if (w_hs) begin
                    addr_d = addr_q + {32'd0, w_len};
                    rem_d  = rem_q - {32'd0, w_len};
                    if (w_last) begin
                        // A completion pulse coincident with the final grant is kept
                        if (state_q == S_REQ_CENT) begin
                            pend_d  = dp_cent_done;
                            state_d = S_WAIT_CENT;
                        end else begin
                            pend_d  = dp_pass_done;
                            state_d = S_WAIT_DATA;
                        end
                    end
                end
            end
            S_WAIT_CENT: begin
                if (dp_cent_done || pend_q) begin
                    pend_d  = 1'b0;
                    rem_d   = w_data_bytes;
                    addr_d  = dbase_q;
                    state_d = S_REQ_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (dp_pass_done || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_WAIT_UPD;
                end
            end
            S_WAIT_UPD: begin
                if (upd_done) begin
                    delta_d = upd_delta;
                    if (iter_q != 16'hFFFF) begin
                        iter_d = iter_q + 16'd1;
                    end
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (delta_q <= thresh_q) begin
                    conv_d  = 1'b1;
                    state_d = S_FIN;
                end else if (iter_q == maxi_q) begin
                    conv_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any handshake or completion seen in the same cycle
        if (abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            addr_d  = addr_q;
            rem_d   = rem_q;
            pend_d  = pend_q;
            delta_d = delta_q;
            iter_d  = iter_q;
            err_d   = err_q;
            conv_d  = 1'b0;
            state_d = S_FIN;
        end
    end

`ifdef KMEANS_ITER_CTRL_PERF_EN
    // Performance counters clear on an accepted start and otherwise accumulate
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if ((state_q == S_IDLE) && start) begin
            perf_cycles_d = 64'd0;
            perf_stall_d  = 64'd0;
        end else begin
            if (busy_q) begin
                perf_cycles_d = perf_cycles_q + 64'd1;
            end
            if (rd_req_valid && !rd_req_ready) begin
                perf_stall_d = perf_stall_q + 64'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_cycles_q <= 64'd0;
            perf_stall_q  <= 64'd0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            dim_q    <= '0;
            size_q   <= 64'd0;
            maxi_q   <= 16'd0;
            thresh_q <= 32'd0;
            cbase_q  <= 64'd0;
            dbase_q  <= 64'd0;
            addr_q   <= 64'd0;
            rem_q    <= 64'd0;
            pend_q   <= 1'b0;
            delta_q  <= 32'd0;
            iter_q   <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            dim_q    <= dim_d;
            size_q   <= size_d;
            maxi_q   <= maxi_d;
            thresh_q <= thresh_d;
            cbase_q  <= cbase_d;
            dbase_q  <= dbase_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            pend_q   <= pend_d;
            delta_q  <= delta_d;
            iter_q   <= iter_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            conv_q   <= conv_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_k_means_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k_means_iter_ctrl
//  Description : Self-checking bench for k_means_iter_ctrl: directed table of
//                configurations, hand-written stall/abort sequence and
//                randomized jobs checked against a descriptor-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k_means_iter_ctrl;

    localparam int XFER = 4096;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [3:0]  num_clusters = '0;
    logic [9:0]  data_dim = '0;
    logic [63:0] data_set_size = '0;
    logic [15:0] max_iter = '0;
    logic [31:0] conv_thresh = '0;
    logic [63:0] cent_base = '0, data_base = '0;
    logic        rd_req_valid, rd_req_ready = 1'b0;
    logic [63:0] rd_req_addr;
    logic [31:0] rd_req_len;
    logic        rd_req_cent;
    logic        dp_cent_done = 1'b0, dp_pass_done = 1'b0, upd_done = 1'b0;
    logic [31:0] upd_delta = '0;
    logic        iter_start, busy, done, converged, err;
    logic [15:0] iter_count;
`ifdef KMEANS_ITER_CTRL_PERF_EN
    logic [63:0] perf_cycles, perf_stall;
`endif

    always #5 aclk = ~aclk;

    k_means_iter_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .num_clusters(num_clusters), .data_dim(data_dim),
        .data_set_size(data_set_size), .max_iter(max_iter),
        .conv_thresh(conv_thresh), .cent_base(cent_base), .data_base(data_base),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_cent(rd_req_cent),
        .dp_cent_done(dp_cent_done), .dp_pass_done(dp_pass_done),
        .upd_done(upd_done), .upd_delta(upd_delta),
        .iter_start(iter_start), .busy(busy), .done(done),
        .converged(converged), .err(err), .iter_count(iter_count)
`ifdef KMEANS_ITER_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic        cent;
    } desc_t;

    typedef struct {
        logic [3:0]  k;
        logic [9:0]  dim;
        logic [63:0] size;
        logic [15:0] mi;
        logic [31:0] th;
        logic [63:0] cb;
        logic [63:0] db;
        logic [31:0] delta;
        int          exp_ndesc;
        int          exp_iters;
        bit          exp_conv;
        bit          exp_err;
    } cfg_t;

    int          n_checks = 0;
    int          n_errors = 0;
    desc_t       got_q[$];
    desc_t       exp_q[$];
    logic [31:0] dl[8];
    int          res_cycles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split a byte range into boundary-respecting descriptors
    function automatic void add_descs(input logic [63:0] base, input logic [63:0] bytes, input logic cent);
        logic [63:0] a = base;
        logic [63:0] r = bytes;
        logic [63:0] room;
        logic [63:0] l;
        while (r != 64'd0) begin
            room = 64'(XFER) - (a % 64'(XFER));
            l    = (r < room) ? r : room;
            exp_q.push_back('{a, l[31:0], cent});
            a = a + l;
            r = r - l;
        end
    endfunction

    // Reference: whole job as a list of descriptors plus the final status
    function automatic void model_job(input cfg_t c, output int n_it, output bit conv, output bit e);
        int eff = (c.mi == 16'd0) ? 1 : int'(c.mi);
        n_it = 0;
        conv = 1'b0;
        e    = 1'b0;
        if (c.k == 4'd0 || c.dim == 10'd0 || c.size == 64'd0) begin
            e = 1'b1;
            return;
        end
        while (1) begin
            add_descs(c.cb, 64'(c.k) * 64'(c.dim) * 64'd4, 1'b1);
            add_descs(c.db, c.size * 64'd64, 1'b0);
            n_it++;
            if (dl[n_it-1] <= c.th) begin
                conv = 1'b1;
                break;
            end
            if (n_it == eff) break;
        end
    endfunction

    // Run one job end to end, acting as the host memory and datapath
    task automatic run_job(input cfg_t c, input int rdy_pct, input bit early, input string tag);
        int          n_it, phase, dly, it_idx, pulses, cyc;
        bit          m_conv, m_err, prev_pend, timed_out, hs;
        desc_t       prev_d;
        logic [63:0] cbytes, dbytes, acc;
        got_q.delete();
        exp_q.delete();
        model_job(c, n_it, m_conv, m_err);
        cbytes = 64'(c.k) * 64'(c.dim) * 64'd4;
        dbytes = c.size * 64'd64;
        num_clusters = c.k; data_dim = c.dim; data_set_size = c.size;
        max_iter = c.mi; conv_thresh = c.th; cent_base = c.cb; data_base = c.db;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check({tag, "_start_clr_done"}, done, 0);
        check({tag, "_start_clr_iter"}, iter_count, 0);
        phase = 0; dly = 0; it_idx = 0; pulses = 0; acc = 0;
        prev_pend = 1'b0; timed_out = 1'b1;
        for (cyc = 1; cyc <= 20000; cyc++) begin
            dp_cent_done = 1'b0; dp_pass_done = 1'b0; upd_done = 1'b0; start = 1'b0;
            if (iter_start) pulses++;
            if (prev_pend) begin
                check({tag, "_hold_valid"}, rd_req_valid, 1);
                check({tag, "_hold_addr"}, rd_req_addr, prev_d.addr);
                check({tag, "_hold_len"}, rd_req_len, prev_d.len);
            end
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            rd_req_ready = ($urandom_range(99) < rdy_pct);
            hs = rd_req_valid && rd_req_ready;
            if (hs) begin
                got_q.push_back('{rd_req_addr, rd_req_len, rd_req_cent});
                acc = acc + 64'(rd_req_len);
            end
            prev_pend = rd_req_valid && !rd_req_ready;
            prev_d    = '{rd_req_addr, rd_req_len, rd_req_cent};
            case (phase)
                0: if (hs && acc == cbytes) begin
                       acc = 0;
                       if (early) begin dp_cent_done = 1'b1; phase = 2; end
                       else begin phase = 1; dly = $urandom_range(3); end
                   end
                1: if (dly == 0) begin dp_cent_done = 1'b1; phase = 2; end
                   else dly--;
                2: if (hs && acc == dbytes) begin
                       acc = 0;
                       if (early) begin dp_pass_done = 1'b1; phase = 4; dly = 2 + $urandom_range(2); end
                       else begin phase = 3; dly = $urandom_range(3); end
                   end
                3: if (dly == 0) begin dp_pass_done = 1'b1; phase = 4; dly = 1 + $urandom_range(2); end
                   else dly--;
                default: if (dly == 0) begin
                       upd_done  = 1'b1;
                       upd_delta = dl[it_idx % 8];
                       it_idx++;
                       phase = 0;
                   end else dly--;
            endcase
            if (busy && $urandom_range(49) == 0) start = 1'b1;
            @(negedge aclk);
        end
        rd_req_ready = 1'b0;
        start = 1'b0;
        res_cycles = cyc;
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, m_err);
        check({tag, "_conv"}, converged, m_conv);
        check({tag, "_iter_count"}, iter_count, n_it);
        check({tag, "_iter_pulses"}, pulses, n_it);
        check({tag, "_ndesc"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_d_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_d_len"}, got_q[i].len, exp_q[i].len);
            check({tag, "_d_cent"}, got_q[i].cent, exp_q[i].cent);
        end
    endtask

    // Latency, back-pressure stability, perf counters and abort
    task automatic seq_stall_abort();
        num_clusters = 4'd4; data_dim = 10'd8; data_set_size = 64'd128;
        max_iter = 16'd1; conv_thresh = 32'd0;
        cent_base = 64'h1000; data_base = 64'h10000;
        rd_req_ready = 1'b0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("lat_c1_valid", rd_req_valid, 0);
        check("busy_after_start", busy, 1);
        @(negedge aclk);
        check("lat_c2_valid", rd_req_valid, 0);
        check("iter_start_pulse", iter_start, 1);
        @(negedge aclk);
        check("lat_c3_valid", rd_req_valid, 1);
        check("iter_start_single", iter_start, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", rd_req_addr, 64'h1000);
            check("stall_len", rd_req_len, 128);
            check("stall_cent", rd_req_cent, 1);
            if (i < 4) @(negedge aclk);
        end
        @(negedge aclk);
        check("stall_valid_before_grant", rd_req_valid, 1);
        rd_req_ready = 1'b1;
        @(negedge aclk);
        rd_req_ready = 1'b0;
        check("one_handshake", rd_req_valid, 0);
`ifdef KMEANS_ITER_CTRL_PERF_EN
        check("perf_stall", perf_stall, 5);
        check("perf_cycles", perf_cycles, 8);
`endif
        dp_cent_done = 1'b1;
        @(negedge aclk);
        dp_cent_done = 1'b0;
        check("data_valid", rd_req_valid, 1);
        check("data_cent", rd_req_cent, 0);
        check("data_addr", rd_req_addr, 64'h10000);
        check("data_len", rd_req_len, 4096);
        @(negedge aclk);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        check("abort_drop_valid", rd_req_valid, 0);
        @(negedge aclk);
        check("abort_done", done, 1);
        check("abort_conv", converged, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_iter", iter_count, 0);
    endtask

    cfg_t tbl[10];

    initial begin
        //        k      dim     size     mi     th      cb           db            delta  nd it cv er
        tbl[0] = '{4'd4, 10'd8, 64'd128, 16'd1, 32'd0,  64'h1000, 64'h10000, 32'd0,  3, 1, 1, 0};
        tbl[1] = '{4'd4, 10'd8, 64'd128, 16'd3, 32'd10, 64'h1000, 64'h10000, 32'd50, 9, 3, 0, 0};
        tbl[2] = '{4'd4, 10'd8, 64'd128, 16'd1, 32'd0,  64'h0F80, 64'h10000, 32'd0,  3, 1, 1, 0};
        tbl[3] = '{4'd4, 10'd8, 64'd128, 16'd1, 32'd0,  64'h0FC0, 64'h10000, 32'd0,  4, 1, 1, 0};
        tbl[4] = '{4'd0, 10'd8, 64'd128, 16'd1, 32'd0,  64'h1000, 64'h10000, 32'd0,  0, 0, 0, 1};
        tbl[5] = '{4'd4, 10'd0, 64'd128, 16'd1, 32'd0,  64'h1000, 64'h10000, 32'd0,  0, 0, 0, 1};
        tbl[6] = '{4'd4, 10'd8, 64'd0,   16'd1, 32'd0,  64'h1000, 64'h10000, 32'd0,  0, 0, 0, 1};
        tbl[7] = '{4'd4, 10'd8, 64'd128, 16'd0, 32'd10, 64'h1000, 64'h10000, 32'd50, 3, 1, 0, 0};
        tbl[8] = '{4'd4, 10'd8, 64'd128, 16'd3, 32'd10, 64'h1000, 64'h10000, 32'd10, 3, 1, 1, 0};
        tbl[9] = '{4'd4, 10'd8, 64'd128, 16'd1, 32'd0,  64'h1000, 64'h10800, 32'd0,  4, 1, 1, 0};

        repeat (3) @(negedge aclk);
        check("rst_valid", rd_req_valid, 0);
        check("rst_addr", rd_req_addr, 0);
        check("rst_len", rd_req_len, 0);
        check("rst_status", {iter_start, busy, done, converged, err, rd_req_cent}, 0);
        check("rst_iter", iter_count, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        seq_stall_abort();

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) dl[j] = tbl[i].delta;
            run_job(tbl[i], 100, i[0], $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_exp_ndesc", i), got_q.size(), tbl[i].exp_ndesc);
            check($sformatf("tbl%0d_exp_iters", i), iter_count, tbl[i].exp_iters);
            check($sformatf("tbl%0d_exp_conv", i), converged, tbl[i].exp_conv);
            check($sformatf("tbl%0d_exp_err", i), err, tbl[i].exp_err);
            if (tbl[i].exp_err) check($sformatf("tbl%0d_err_fast", i), res_cycles <= 3, 1);
            if (i == 0 && got_q.size() >= 3) begin
                check("tp_cent_addr", got_q[0].addr, 64'h1000);
                check("tp_cent_len", got_q[0].len, 128);
                check("tp_data0_addr", got_q[1].addr, 64'h10000);
                check("tp_data1_addr", got_q[2].addr, 64'h11000);
                check("tp_data1_len", got_q[2].len, 4096);
            end
            if (i == 3 && got_q.size() >= 2) begin
                check("tp_split0", {got_q[0].addr, got_q[0].len}, {64'h0FC0, 32'd64});
                check("tp_split1", {got_q[1].addr, got_q[1].len}, {64'h1000, 32'd64});
            end
        end

        for (int r = 0; r < 40; r++) begin
            cfg_t c;
            c.k    = ($urandom_range(9) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            c.dim  = ($urandom_range(9) == 0) ? 10'd0 : 10'($urandom_range(24, 1));
            c.size = ($urandom_range(14) == 0) ? 64'd0 : 64'($urandom_range(150, 1));
            c.mi   = 16'($urandom_range(5));
            c.th   = 32'($urandom_range(100));
            c.cb   = {32'($urandom), 32'($urandom)};
            c.db   = {32'($urandom), 32'($urandom)};
            c.delta = 32'd0;
            c.exp_ndesc = 0; c.exp_iters = 0; c.exp_conv = 1'b0; c.exp_err = 1'b0;
            for (int j = 0; j < 8; j++) dl[j] = 32'($urandom_range(150));
            run_job(c, $urandom_range(100, 30), 1'($urandom_range(1)), $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
